// File: rtl/bloco_operacional.sv
// bloco_operacional: 8-bit accumulator datapath (AC, PC, REM, RDM, RI, OUT, N/Z, ULA, 256x8 memory).
// Memory starts zeroed; programs are loaded through writeMEM.
module bloco_operacional (
  input  logic       clk,
  input  logic       reset,
  input  logic       writeAC,
  input  logic       writePC,
  input  logic       writeN,
  input  logic       writeZ,
  input  logic       writeMEM,
  input  logic       writeRDM,
  input  logic       writeRI,
  input  logic       writeOUT,
  input  logic       writeREM,
  input  logic       selectREM,
  input  logic       incrementPC,
  input  logic [1:0] selectRDM,
  input  logic [2:0] opULA,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       sNOP,
  output logic       sSTA,
  output logic       sLDA,
  output logic       sADD,
  output logic       sOR,
  output logic       sAND,
  output logic       sNOT,
  output logic       sSUB,
  output logic       sJ,
  output logic       sJN,
  output logic       sJZ,
  output logic       sIN,
  output logic       sOUT,
  output logic       sSHR,
  output logic       sSHL,
  output logic       sHLT,
  output logic       sDIR,
  output logic       sIND,
  output logic       sIM,
  output logic       sSOP,
  output logic       sN,
  output logic       sZ,
  output logic [7:0] pc_dbg
);

  logic [7:0] ac_q, ac_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] rdm_q, rdm_d;
  logic [7:0] ri_q, ri_d;
  logic [7:0] out_q, out_d;
  logic       n_q, n_d;
  logic       z_q, z_d;
  logic [7:0] ula;
  logic [7:0] mem_rd;
  logic [15:0] dec;

  logic [7:0] mem_q [256] = '{default: 8'h00};

  assign mem_rd = mem_q[rem_q];

  always_comb begin
    ula = rdm_q;
    unique case (opULA)
      3'b000: ula = ac_q + rdm_q;
      3'b001: ula = ac_q & rdm_q;
      3'b010: ula = ac_q | rdm_q;
      3'b011: ula = ~ac_q;
      3'b100: ula = ac_q - rdm_q;
      3'b101: ula = {1'b0, ac_q[7:1]};
      3'b110: ula = {ac_q[6:0], 1'b0};
      3'b111: ula = rdm_q;
    endcase
  end

  always_comb begin
    ac_d  = writeAC  ? ula : ac_q;
    n_d   = writeN   ? ula[7] : n_q;
    z_d   = writeZ   ? (ula == 8'h00) : z_q;
    ri_d  = writeRI  ? rdm_q : ri_q;
    out_d = writeOUT ? ac_q : out_q;
    rem_d = rem_q;
    if (writeREM) rem_d = selectREM ? rdm_q : pc_q;
    rdm_d = rdm_q;
    if (writeRDM) begin
      unique case (selectRDM)
        2'b00: rdm_d = mem_rd;
        2'b01: rdm_d = ac_q;
        2'b10: rdm_d = pc_q;
        2'b11: rdm_d = data_in;
      endcase
    end
    pc_d = pc_q;
    if (writePC)          pc_d = rdm_q;
    else if (incrementPC) pc_d = pc_q + 8'h01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ac_q  <= '0;
      pc_q  <= '0;
      rem_q <= '0;
      rdm_q <= '0;
      ri_q  <= '0;
      out_q <= '0;
      n_q   <= 1'b0;
      z_q   <= 1'b1;
    end else begin
      ac_q  <= ac_d;
      pc_q  <= pc_d;
      rem_q <= rem_d;
      rdm_q <= rdm_d;
      ri_q  <= ri_d;
      out_q <= out_d;
      n_q   <= n_d;
      z_q   <= z_d;
    end
  end

  always_ff @(posedge clk) begin
    if (writeMEM && !reset) mem_q[rem_q] <= rdm_q;
  end

  assign dec = 16'h0001 << ri_q[7:4];

  assign sNOP = dec[0];
  assign sSTA = dec[1];
  assign sLDA = dec[2];
  assign sADD = dec[3];
  assign sOR  = dec[4];
  assign sAND = dec[5];
  assign sNOT = dec[6];
  assign sSUB = dec[7];
  assign sJ   = dec[8];
  assign sJN  = dec[9];
  assign sJZ  = dec[10];
  assign sIN  = dec[11];
  assign sOUT = dec[12];
  assign sSHR = dec[13];
  assign sSHL = dec[14];
  assign sHLT = dec[15];

  assign sIND = (ri_q[1:0] == 2'b01);
  assign sIM  = (ri_q[1:0] == 2'b10);
  assign sDIR = !sIND && !sIM;
  assign sSOP = sNOP | sNOT | sIN | sOUT | sSHR | sSHL | sHLT;

  assign sN       = n_q;
  assign sZ       = z_q;
  assign data_out = out_q;
  assign pc_dbg   = pc_q;

endmodule
